mem_boot_loader: RTL and testbench

Boot loader that sits directly upstream of the main memory's port B. It receives a byte stream from the host-link receiver, assembles 18-bit words and writes them into consecutive main-memory addresses. It checks the image length and checksum, and holds the CPU in reset until the load completes. The CPU keeps port A throughout; the loader owns port B only while busy.

---
 rtl/mem_boot_loader_pkg.sv | 32 +++
 rtl/mem_boot_word_asm.sv | 47 ++++
 rtl/mem_boot_loader.sv | 152 +++++++++++++++
 tb/tb_mem_boot_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_boot_loader_pkg.sv
`default_nettype none
// mem_boot_loader_pkg: shared widths, stream-format constants and FSM state type.
// Rev 1.0
package mem_boot_loader_pkg;

    localparam int DATA_W         = 18;
    localparam int ADDR_W         = 14;
    localparam int MEM_WORDS      = 11264;
    localparam int BYTES_PER_WORD = 3;
    localparam int HDR_BYTES      = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_WRITE,
        ST_VERIFY,
        ST_VCMP,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    // Bytes to discard after an out-of-range header, not counting the checksum byte.
    function automatic logic [8*HDR_BYTES-1:0] drain_count(input logic [8*HDR_BYTES-1:0] n);
        return n * (8*HDR_BYTES)'(BYTES_PER_WORD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_boot_word_asm.sv
`default_nettype none
// mem_boot_word_asm: packs three stream bytes into one 18-bit word and keeps the payload XOR.
// Rev 1.0
module mem_boot_word_asm
    import mem_boot_loader_pkg::*;
(
    input  logic              clka,
    input  logic              reset,
    input  logic              clear,
    input  logic              take,
    input  logic [1:0]        sel,
    input  logic [7:0]        rx_byte,
    output logic [DATA_W-1:0] word,
    output logic              word_valid,
    output logic [7:0]        csum
);

    logic [1:0] hi_bits;
    logic [7:0] mid_byte;

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            hi_bits    <= '0;
            mid_byte   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            csum       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                csum <= '0;
            end else if (take) begin
                csum <= csum ^ rx_byte;
                case (sel)
                    2'd0:    hi_bits  <= rx_byte[1:0];
                    2'd1:    mid_byte <= rx_byte;
                    default: begin
                        word       <= {hi_bits, mid_byte, rx_byte};
                        word_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_boot_loader.sv
`default_nettype none
// mem_boot_loader: streams a length-prefixed, checksummed image into memory port B.
// Rev 1.0 -- MEM_BOOT_VERIFY_EN adds a read-back check after every write.
module mem_boot_loader
    import mem_boot_loader_pkg::*;
#(
    parameter int DATA      = DATA_W,
    parameter int ADDR      = ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int MEM_WORDS = mem_boot_loader_pkg::MEM_WORDS
) (
    input  logic            clka,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      rx_byte,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic [ADDR-1:0] addrb,
    output logic [DATA-1:0] dinb,
    output logic            web,
    input  logic [DATA-1:0] doutb,
    output logic            busy,
    output logic            done,
    output logic [1:0]      err,
    output logic            cpu_hold
);

    state_t                   state, next;
    logic                     xfer;
    logic [5:0]               len_hi;
    logic [8*HDR_BYTES-1:0]   len_word;
    logic                     len_bad;
    logic [8*HDR_BYTES-1:0]   cnt;
    logic                     last_word;
    logic [ADDR-1:0]          addr;
    logic                     csum_bad;
    logic                     asm_take;
    logic [1:0]               asm_sel;
    logic [DATA-1:0]          word;
    logic                     word_valid;
    logic [7:0]               csum;

    assign rx_ready  = state inside {ST_LEN_HI, ST_LEN_LO, ST_B0, ST_B1, ST_B2, ST_CSUM, ST_DRAIN};
    assign xfer      = rx_valid && rx_ready;
    assign busy      = (state != ST_IDLE);
    assign web       = (state == ST_WRITE) && word_valid;
    assign addrb     = addr;
    assign dinb      = word;
    // Bits [15:14] of the length field are dropped here.
    assign len_word  = {2'b00, len_hi, rx_byte};
    assign len_bad   = (32'(BASE_ADDR) + 32'(len_word)) > 32'(MEM_WORDS);
    assign last_word = (cnt == (8*HDR_BYTES)'(1));
    assign csum_bad  = (rx_byte != csum);
    assign asm_take  = xfer && (state inside {ST_B0, ST_B1, ST_B2});
    assign asm_sel   = (state == ST_B0) ? 2'd0 : (state == ST_B1) ? 2'd1 : 2'd2;

    mem_boot_word_asm u_word_asm (
        .clka       (clka),
        .reset      (reset),
        .clear      ((state == ST_IDLE) && start),
        .take       (asm_take),
        .sel        (asm_sel),
        .rx_byte    (rx_byte),
        .word       (word),
        .word_valid (word_valid),
        .csum       (csum)
    );

    always_ff @(posedge clka or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            ST_IDLE:   if (start) next = ST_LEN_HI;
            ST_LEN_HI: if (xfer) next = ST_LEN_LO;
            ST_LEN_LO: if (xfer) next = len_bad ? ST_DRAIN :
                                        (len_word == '0) ? ST_CSUM : ST_B0;
            ST_B0:     if (xfer) next = ST_B1;
            ST_B1:     if (xfer) next = ST_B2;
            ST_B2:     if (xfer) next = ST_WRITE;
`ifdef MEM_BOOT_VERIFY_EN
            ST_WRITE:  next = ST_VERIFY;
            ST_VERIFY: next = ST_VCMP;
            ST_VCMP:   next = last_word ? ST_CSUM : ST_B0;
`else
            ST_WRITE:  next = last_word ? ST_CSUM : ST_B0;
`endif
            ST_CSUM:   if (xfer) next = ST_IDLE;
            ST_DRAIN:  if (xfer && cnt == '0) next = ST_IDLE;
            default:   next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            len_hi   <= '0;
            cnt      <= '0;
            addr     <= ADDR'(BASE_ADDR);
            done     <= 1'b0;
            err      <= 2'b00;
            cpu_hold <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    done     <= 1'b0;
                    err      <= 2'b00;
                    cpu_hold <= 1'b1;
                    addr     <= ADDR'(BASE_ADDR);
                end
                ST_LEN_HI: if (xfer) len_hi <= rx_byte[5:0];
                ST_LEN_LO: if (xfer) begin
                    if (len_bad) begin
                        err[1] <= 1'b1;
                        cnt    <= drain_count(len_word);
                    end else begin
                        cnt <= len_word;
                    end
                end
`ifdef MEM_BOOT_VERIFY_EN
                ST_VCMP: begin
                    if (doutb != word) err[0] <= 1'b1;
                    addr <= addr + ADDR'(1);
                    cnt  <= cnt - (8*HDR_BYTES)'(1);
                end
`else
                ST_WRITE: begin
                    addr <= addr + ADDR'(1);
                    cnt  <= cnt - (8*HDR_BYTES)'(1);
                end
`endif
                ST_CSUM: if (xfer) begin
                    // A read-back error may already be latched, so success needs both clean.
                    if (csum_bad) err[0] <= 1'b1;
                    done     <= !csum_bad && (err == 2'b00);
                    cpu_hold <= csum_bad || (err != 2'b00);
                end
                ST_DRAIN: if (xfer && cnt != '0) cnt <= cnt - (8*HDR_BYTES)'(1);
                default: ;
            endcase
        end
    end

`ifndef MEM_BOOT_VERIFY_EN
    logic unused_doutb;
    assign unused_doutb = ^doutb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_boot_loader.sv
`default_nettype none
// tb_mem_boot_loader: randomized loads checked against a word-list reference model.
// Rev 1.0
module tb_mem_boot_loader;

    localparam int MEMW = 11264;

    logic        clka = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic [13:0] addrb;
    logic [17:0] dinb;
    logic        web;
    logic [17:0] doutb;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic        cpu_hold;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] mem [0:16383];
    logic [17:0] words [0:63];
    logic [13:0] wr_addr_q[$];
    logic [17:0] wr_data_q[$];

`ifdef MEM_BOOT_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    mem_boot_loader dut (
        .clka     (clka),
        .reset    (reset),
        .start    (start),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .addrb    (addrb),
        .dinb     (dinb),
        .web      (web),
        .doutb    (doutb),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clka = ~clka;

    // Port-B memory model; reads of address 5 come back with bit0 flipped.
    always @(posedge clka) begin
        if (web) mem[addrb] <= dinb;
        doutb <= mem[addrb] ^ ((addrb == 14'd5) ? 18'd1 : 18'd0);
    end

    always @(negedge clka) begin
        if (web) begin
            wr_addr_q.push_back(addrb);
            wr_data_q.push_back(dinb);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int k;
        if (gappy) begin
            rx_valid = 1'b0;
            @(posedge clka); #1;
        end
        rx_byte  = b;
        rx_valid = 1'b1;
        k = 0;
        while (!rx_ready && k < 50) begin
            @(posedge clka); #1;
            k++;
        end
        if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clka); #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clka); #1;
        start = 1'b0;
    endtask

    task automatic run_load(input int n, input bit bad_csum, input bit gappy, input bit poke_start);
        logic [7:0]  cs, b, hi;
        logic [1:0]  junk;
        logic [15:0] nv;
        bit          in_range, exp_e0, exp_done;
        int          k, n_wr;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("hold_after_start", 32'(cpu_hold), 32'd1);
        check("err_cleared", 32'(err), 32'd0);
        nv   = 16'(n);
        junk = 2'($urandom);
        hi   = {junk, nv[13:8]};
        send_byte(hi, gappy);
        send_byte(nv[7:0], gappy);
        if (poke_start) pulse_start();
        cs = 8'h00;
        in_range = (n <= MEMW);
        if (!in_range) begin
            for (int i = 0; i < n * 3; i++) begin
                b = 8'($urandom);
                cs ^= b;
                send_byte(b, 1'b0);
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                b = {6'($urandom), words[i][17:16]};
                cs ^= b; send_byte(b, gappy);
                b = words[i][15:8];
                cs ^= b; send_byte(b, gappy);
                b = words[i][7:0];
                cs ^= b; send_byte(b, gappy);
                check("web_after_b2", 32'(web), 32'd1);
                check("addr_after_b2", 32'(addrb), 32'(i));
                check("din_after_b2", 32'(dinb), 32'(words[i]));
            end
        end
        send_byte(cs ^ (bad_csum ? 8'h01 : 8'h00), gappy);
        k = 0;
        while (busy && k < 20) begin
            @(posedge clka); #1;
            k++;
        end
        exp_e0   = in_range && (bad_csum || (VERIFY && n > 5));
        exp_done = in_range && !exp_e0;
        check("busy_end", 32'(busy), 32'd0);
        check("err_end", 32'(err), 32'({!in_range, exp_e0}));
        check("done_end", 32'(done), 32'(exp_done));
        check("hold_end", 32'(cpu_hold), 32'(!exp_done));
        n_wr = in_range ? n : 0;
        check("write_count", 32'(wr_addr_q.size()), 32'(n_wr));
        for (int i = 0; i < n_wr && i < wr_addr_q.size(); i++) begin
            check("wr_addr", 32'(wr_addr_q[i]), 32'(i));
            check("wr_data", 32'(wr_data_q[i]), 32'(words[i]));
            check("mem_word", 32'(mem[i]), 32'(words[i]));
        end
    endtask

    task automatic rand_words(input int n);
        for (int i = 0; i < n; i++) words[i] = 18'($urandom);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_addrb", 32'(addrb), 32'd0);
        check("rst_dinb", 32'(dinb), 32'd0);
        check("rst_web", 32'(web), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        reset = 1'b0;
        @(posedge clka); #1;

        run_load(0, 1'b0, 1'b0, 1'b0);

        words[0] = 18'h3FFFF;
        words[1] = 18'h00001;
        run_load(2, 1'b0, 1'b0, 1'b0);

        words[0] = 18'h12345;
        run_load(1, 1'b1, 1'b0, 1'b0);

        rand_words(3);
        run_load(3, 1'b0, 1'b1, 1'b0);
        run_load(3, 1'b0, 1'b0, 1'b0);

        // Abort between the b1 and b2 handshakes, then reload.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'hAB, 1'b0);
        reset = 1'b1;
        #1;
        check("abort_web", 32'(web), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hold", 32'(cpu_hold), 32'd1);
        @(posedge clka); #1;
        reset = 1'b0;
        @(posedge clka); #1;
        check("abort_writes", 32'(wr_addr_q.size()), 32'd0);
        rand_words(2);
        run_load(2, 1'b0, 1'b0, 1'b0);

        rand_words(8);
        run_load(8, 1'b0, 1'b0, 1'b1);

        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(1, 20);
            rand_words(n);
            run_load(n, 1'($urandom), 1'($urandom), 1'b0);
        end

        run_load(11265, 1'b0, 1'b0, 1'b0);

        rand_words(4);
        run_load(4, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
